// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide valid/ready in, asynchronous serial frame out.
// Ports: clock, reset_n (async, active-low), baud_tick (bit boundary pulse),
//        tx_valid/tx_data/tx_ready (byte handshake), tx (serial line,
//        registered, idle high), busy (not idle), tx_done (frame end pulse).
// Build option: define UART_TX_PARITY_EN to send a parity bit (even, or odd
//        when PARITY_ODD=1) between the data and stop bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`else
    // Parity type has no effect in this build.
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic. The IDLE branch ignores baud_tick, so a tick
    // coincident with acceptance never shortens the start bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_ARM;
                    shreg_d = tx_data;
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_ARM: begin
                if (baud_tick) state_d = S_START;
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. The line level is decoded from the next state so the
    // registered tx changes on the same edge that samples baud_tick.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame vectors for uart_tx_serializer
// with a tick every 4 clocks, plus reset and back-to-back sequences.
module tb_uart_tx_serializer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, busy, tx_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_serializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    logic tx_ready_o, tx_o, busy_o, tx_done_o;
    uart_tx_serializer #(.PARITY_ODD(1)) dut_odd (
        .clock     (clock),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready_o),
        .tx        (tx_o),
        .busy      (busy_o),
        .tx_done   (tx_done_o)
    );
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        bit         coin;
        string      nm;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line levels per tick: start, data LSB first, [parity], stop.
    function automatic logic [10:0] mk_seq(input logic [7:0] d,
                                           input logic p);
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, 1'b1 | p, d, 1'b0};
`endif
    endfunction

    task automatic accept(input logic [7:0] d, input bit coin,
                          input bit hold, input string nm);
        tx_valid  = 1'b1;
        tx_data   = d;
        baud_tick = coin;
        chk({nm, " ready pre"}, 32'(tx_ready), 32'd1);
        step();
        baud_tick = 1'b0;
        if (!hold) tx_valid = 1'b0;
        chk({nm, " tx arm"}, 32'(tx), 32'd1);
        chk({nm, " busy arm"}, 32'(busy), 32'd1);
        chk({nm, " ready arm"}, 32'(tx_ready), 32'd0);
    endtask

    task automatic run_ticks(input logic [10:0] seq, input logic pe,
                             input string nm, input bit hold,
                             input logic [7:0] nxt);
        logic prev;
        int   t0;
        prev = 1'b1;
        t0   = 0;
        for (int j = 0; j <= NB; j++) begin
            for (int k = 0; k < 3; k++) begin
                tx_data = 8'($urandom);
                step();
                chk($sformatf("%s hold j%0d", nm, j), 32'(tx), 32'(prev));
            end
            if (j == NB) tx_data = nxt;
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            if (j == 0) t0 = cyc;
            if (j < NB) begin
                chk($sformatf("%s bit%0d", nm, j), 32'(tx), 32'(seq[j]));
                chk($sformatf("%s done%0d", nm, j), 32'(tx_done), 32'd0);
                prev = seq[j];
`ifdef UART_TX_PARITY_EN
                if (j == 9)
                    chk({nm, " odd par"}, 32'(tx_o), 32'(~pe));
`endif
            end else begin
                chk({nm, " tx end"}, 32'(tx), 32'd1);
                chk({nm, " done"}, 32'(tx_done), 32'd1);
                chk({nm, " ready end"}, 32'(tx_ready), 32'd1);
                chk({nm, " busy end"}, 32'(busy), 32'd0);
                chk({nm, " len"}, 32'(cyc - t0), 32'(4 * NB));
            end
        end
        if (!hold) begin
            step();
            chk({nm, " done pulse"}, 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{d: 8'h55, pe: 1'b0, coin: 1'b0, nm: "v55"};
        vecs[1] = '{d: 8'h00, pe: 1'b0, coin: 1'b0, nm: "v00"};
        vecs[2] = '{d: 8'hFF, pe: 1'b0, coin: 1'b1, nm: "vFF"};
        vecs[3] = '{d: 8'h07, pe: 1'b1, coin: 1'b0, nm: "v07"};
        vecs[4] = '{d: 8'h80, pe: 1'b1, coin: 1'b1, nm: "v80"};
        vecs[5] = '{d: 8'h01, pe: 1'b1, coin: 1'b0, nm: "v01"};

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            tx_valid  = 1'($urandom);
            baud_tick = 1'($urandom);
            tx_data   = 8'($urandom);
            step();
            chk($sformatf("rst tx %0d", i), 32'(tx), 32'd1);
            chk($sformatf("rst ready %0d", i), 32'(tx_ready), 32'd1);
            chk($sformatf("rst busy %0d", i), 32'(busy), 32'd0);
            chk($sformatf("rst done %0d", i), 32'(tx_done), 32'd0);
        end
        tx_valid  = 1'b0;
        baud_tick = 1'b0;
        reset_n   = 1'b1;
        step();
        chk("idle tx", 32'(tx), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        // Table-driven frames.
        foreach (vecs[i]) begin
            accept(vecs[i].d, vecs[i].coin, 1'b0, vecs[i].nm);
            run_ticks(mk_seq(vecs[i].d, vecs[i].pe), vecs[i].pe,
                      vecs[i].nm, 1'b0, 8'h00);
            step();
        end

        // Back-to-back: second byte taken in the tx_done cycle.
        accept(8'hA3, 1'b0, 1'b1, "bA3");
        run_ticks(mk_seq(8'hA3, 1'b0), 1'b0, "bA3", 1'b1, 8'h3C);
        accept(8'h3C, 1'b0, 1'b0, "b3C");
        run_ticks(mk_seq(8'h3C, 1'b0), 1'b0, "b3C", 1'b0, 8'h00);
        step();

        // Reset during data bit 3 of an all-zero byte.
        accept(8'h00, 1'b0, 1'b0, "rmid");
        for (int j = 0; j <= 4; j++) begin
            step();
            step();
            step();
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
        end
        chk("rmid bit3", 32'(tx), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid async tx", 32'(tx), 32'd1);
        chk("rmid async busy", 32'(busy), 32'd0);
        chk("rmid async ready", 32'(tx_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            baud_tick = 1'($urandom);
            step();
            chk($sformatf("rmid done %0d", i), 32'(tx_done), 32'd0);
            chk($sformatf("rmid tx %0d", i), 32'(tx), 32'd1);
        end
        baud_tick = 1'b0;
        reset_n   = 1'b1;
        step();
        chk("rmid post done", 32'(tx_done), 32'd0);
        chk("rmid post busy", 32'(busy), 32'd0);
        accept(8'hFF, 1'b0, 1'b0, "rFF");
        run_ticks(mk_seq(8'hFF, 1'b0), 1'b0, "rFF", 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer for the UART path. It takes one parallel byte per valid/ready handshake and shifts it out on `tx` as an asynchronous serial frame. The frame is start bit, data bits LSB first, an optional parity bit, then stop bit(s). Bit timing comes only from `baud_tick`, which is driven directly by the `counted` output of the baud-rate counter upstream.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_TX_PARITY_EN` is defined.
- `clock` input, 1 bit: single clock; all logic is rising-edge.
- `reset_n` input, 1 bit: asynchronous reset, active-low.
- `baud_tick` input, 1 bit: one-cycle pulse marking a bit boundary, from the baud counter's `counted`.
- `tx_valid` input, 1 bit: upstream has a byte on `tx_data`.
- `tx_data` input, `DATA_BITS` wide: byte to send; sampled only on acceptance.
- `tx_ready` output, 1 bit: serializer can accept; high only in IDLE.
- `tx` output, 1 bit: serial line, idle high, registered.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `tx_done` output, 1 bit: one-cycle pulse when the last stop bit completes.

## Operation
- States and what each drives:
  - IDLE: `tx`=1, `tx_ready`=1.
  - ARM: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=`shreg[0]`.
  - PARITY: `tx`=parity bit.
  - STOP: `tx`=1.
- Acceptance occurs on `tx_valid & tx_ready` in IDLE.
  - On acceptance, `tx_data` is copied into `shreg`, the bit counter is cleared, and the state moves to ARM.
- ARM waits for the next `baud_tick`, then moves to START.
  - A `baud_tick` in the same cycle as acceptance is ignored, so the start bit is always a full tick period.
- START, on `baud_tick`: move to DATA with bit counter = 0.
- DATA, on each `baud_tick`:
  - `shreg` shifts right and the bit counter increments.
  - After `DATA_BITS` ticks, move to PARITY if enabled, otherwise STOP.
- PARITY, on `baud_tick`: move to STOP.
- STOP lasts `STOP_BITS` ticks.
  - On the final tick, the state moves to IDLE and `tx_done` pulses in the same cycle the state becomes IDLE.
- Parity is the XOR of the accepted data bits, computed at acceptance; it is inverted when `PARITY_ODD`=1.
- While busy, `tx_valid` is ignored and `tx_data` may change freely.
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, state IDLE, `shreg`=0.
- Reset mid-frame: `tx` returns to 1 asynchronously and the frame is abandoned; no `tx_done` is produced.

## Timing
- Every bit lasts exactly one `baud_tick` period. For counter value N, that is N+1 clocks.
- Frame length in ticks, measured from the first tick after acceptance to `tx_done`: 1 + `DATA_BITS` + P + `STOP_BITS`, where P=1 if parity is enabled, else 0.
- The `tx` transition is registered: it changes on the clock edge where `baud_tick` is sampled high.
- `tx_ready` rises in the cycle after the final stop tick, the same cycle `tx_done` is high.
  - Back-to-back accept is possible that cycle.
  - The next start bit then waits one full tick period (ARM).
- `baud_tick` asserted on consecutive cycles advances one bit per cycle. This is legal but is not a UART rate.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists, and one parity bit, even or odd per `PARITY_ODD`, is sent between data and stop bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are removed, DATA goes directly to STOP, and `PARITY_ODD` is ignored.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with random inputs → `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0 throughout.
- **Basic frame:** tick every 4 clocks, send 0x55 with no parity and `STOP_BITS`=1 → `tx` sequence per tick is 0,1,0,1,0,1,0,1,0,1; `tx_done` pulses 40 clocks after the first post-accept tick edge.
- **Parity:** with `UART_TX_PARITY_EN`, send 0x55 with `PARITY_ODD`=0 → parity bit 0. With `PARITY_ODD`=1 → parity bit 1. Send 0x07 even → parity bit 1.
- **Coincident tick:** `baud_tick` high in the acceptance cycle → `tx` stays 1 until the next tick; the start bit is a full period.
- **Back-to-back:** hold `tx_valid`=1 with 0xA3 then 0x3C; change `tx_data` mid-frame → both frames are correct; the second is accepted in the `tx_done` cycle, and mid-frame data changes have no effect.
- **Reset mid-frame:** assert `reset_n`=0 during DATA bit 3 → `tx`=1 in the same cycle (asynchronous), no `tx_done`; after release, a new 0xFF frame transmits correctly.
